// File: rtl/mdlsm_pkg.sv
// mdlsm_pkg -- shared types and defaults for the batch sequencer.
// Contents:
//   ctrl_state_t   : sequencer state encoding
//   DEF_*          : default parameter values used by the sequencer and watchdog
//   state_is_busy  : decodes which states count as "busy" for the host
package mdlsm_pkg;

  localparam int DEF_LINES   = 64;
  localparam int DEF_FILE_W  = 10;
  localparam int DEF_CNT_W   = 8;
  localparam int DEF_TIMEOUT = 1023;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_READ,
    ST_LOAD1,
    ST_LOAD2,
    ST_CALC,
    ST_WAIT,
    ST_WRITE,
    ST_DONE,
    ST_ERR
  } ctrl_state_t;

  function automatic logic state_is_busy(input ctrl_state_t s);
    return (s == ST_READ)  || (s == ST_LOAD1) || (s == ST_LOAD2) ||
           (s == ST_CALC)  || (s == ST_WAIT)  || (s == ST_WRITE);
  endfunction

endpackage

// File: rtl/mdlsm_batch_ctrl_if.sv
// mdlsm_batch_ctrl_if -- host and datapath signals of the batch sequencer.
// master modport : the sequencer (takes commands, drives strobes/status)
// slave modport  : host plus datapath side (drives commands, takes strobes)
// Signals:
//   start, abort, file_base, file_count : batch commands from the host
//   cal_finish                          : calculation done from the datapath
//   read_file, write_reg1, write_reg2,
//   cal_start, write_file               : one-cycle datapath strobes
//   file_index, line_index              : current file / line
//   busy, finish, error                 : batch status
interface mdlsm_batch_ctrl_if #(
  parameter int FILE_W = 10,
  parameter int CNT_W  = 8,
  parameter int LINE_W = 6
);
  logic              start;
  logic              abort;
  logic [FILE_W-1:0] file_base;
  logic [CNT_W-1:0]  file_count;
  logic              cal_finish;
  logic              read_file;
  logic              write_reg1;
  logic              write_reg2;
  logic              cal_start;
  logic              write_file;
  logic [FILE_W-1:0] file_index;
  logic [LINE_W-1:0] line_index;
  logic              busy;
  logic              finish;
  logic              error;

  modport master (
    input  start, abort, file_base, file_count, cal_finish,
    output read_file, write_reg1, write_reg2, cal_start, write_file,
    output file_index, line_index, busy, finish, error
  );

  modport slave (
    output start, abort, file_base, file_count, cal_finish,
    input  read_file, write_reg1, write_reg2, cal_start, write_file,
    input  file_index, line_index, busy, finish, error
  );
endinterface

// File: rtl/mdlsm_wdog.sv
// mdlsm_wdog -- calculation watchdog.
// Ports:
//   clk, rst (async, active-low)
//   en      : high while the sequencer waits for cal_finish; counter cleared when low
//   clr     : synchronous clear (abort)
//   expired : high during the TIMEOUT-th consecutive enabled cycle
// TIMEOUT = 0 disables the watchdog (expired never asserts).
module mdlsm_wdog
  import mdlsm_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expired
);

  // Counter holds the number of enabled cycles already elapsed, 0..TIMEOUT-1.
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!en || clr || (TIMEOUT == 0)) begin
      cnt_d = '0;
    end else if (cnt_q != LAST) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (TIMEOUT != 0) && en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/mdlsm_batch_ctrl.sv
// mdlsm_batch_ctrl -- batch sequencer for the file-driven calculation flow.
// Walks files file_base .. file_base+file_count-1 and, per file, lines
// 0 .. LINES-1, issuing read / load1 / load2 / calc / write strobes per line,
// waiting for cal_finish in between under a watchdog.
// Ports:
//   clk, rst (async, active-low; forces every output to 0)
//   bus (master modport of mdlsm_batch_ctrl_if): commands in, strobes and
//       status out; all outputs are registered.
module mdlsm_batch_ctrl
  import mdlsm_pkg::*;
#(
  parameter int LINES   = DEF_LINES,
  parameter int LINE_W  = (LINES > 1) ? $clog2(LINES) : 1,
  parameter int FILE_W  = DEF_FILE_W,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic                clk,
  input logic                rst,
  mdlsm_batch_ctrl_if.master bus
);

  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(LINES - 1);

  ctrl_state_t       state_q, state_d;
  logic [FILE_W-1:0] base_q, base_d;
  logic [FILE_W-1:0] file_idx_q, file_idx_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  off_q, off_d;
  logic [LINE_W-1:0] line_q, line_d;

  logic read_file_q, read_file_d;
  logic write_reg1_q, write_reg1_d;
  logic write_reg2_q, write_reg2_d;
  logic cal_start_q, cal_start_d;
  logic write_file_q, write_file_d;
  logic busy_q, busy_d;
  logic finish_q, finish_d;
  logic error_q, error_d;

  logic wd_expired;
  logic last_line;
  logic last_file;
  logic launch;

  mdlsm_wdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .en     (state_q == ST_WAIT),
    .clr    (bus.abort),
    .expired(wd_expired)
  );

  assign last_line = (line_q == LAST_LINE);
  assign last_file = (off_q == count_q - CNT_W'(1));
  // A relaunch from ERR behaves exactly like a start from IDLE.
  assign launch    = bus.start && ((state_q == ST_IDLE) || (state_q == ST_ERR));

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    count_d = count_q;
    off_d   = off_q;
    line_d  = line_q;

    // Abort outranks everything, including cal_finish, expiry and a relaunch.
    if ((state_q != ST_IDLE) && bus.abort) begin
      state_d = ST_IDLE;
    end else if (launch) begin
      if (bus.file_count != '0) begin
        base_d  = bus.file_base;
        count_d = bus.file_count;
        off_d   = '0;
        line_d  = '0;
        state_d = ST_READ;
      end else begin
        state_d = ST_DONE;
      end
    end else begin
      case (state_q)
        ST_READ:  state_d = ST_LOAD1;
        ST_LOAD1: state_d = ST_LOAD2;
        ST_LOAD2: state_d = ST_CALC;
        ST_CALC:  state_d = ST_WAIT;
        ST_WAIT: begin
          // cal_finish wins over an expiry landing in the same cycle.
          if (bus.cal_finish) begin
            state_d = ST_WRITE;
          end else if (wd_expired) begin
            state_d = ST_ERR;
          end
        end
        ST_WRITE: begin
          if (last_line) begin
            if (last_file) begin
              state_d = ST_DONE;
            end else begin
              line_d  = '0;
              off_d   = off_q + CNT_W'(1);
              state_d = ST_READ;
            end
          end else begin
            line_d  = line_q + LINE_W'(1);
            state_d = ST_READ;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = state_q;
      endcase
    end

    // Outputs are decoded from the next state so they are registered yet
    // still line up with the state they belong to.
    read_file_d  = (state_d == ST_READ);
    write_reg1_d = (state_d == ST_LOAD1);
    write_reg2_d = (state_d == ST_LOAD2);
    cal_start_d  = (state_d == ST_CALC);
    write_file_d = (state_d == ST_WRITE);
    busy_d       = state_is_busy(state_d);
    finish_d     = (state_d == ST_DONE);
    error_d      = (state_d == ST_ERR);
    // Wraps modulo 2^FILE_W by construction.
    file_idx_d   = base_d + FILE_W'(off_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      base_q       <= '0;
      count_q      <= '0;
      off_q        <= '0;
      line_q       <= '0;
      file_idx_q   <= '0;
      read_file_q  <= 1'b0;
      write_reg1_q <= 1'b0;
      write_reg2_q <= 1'b0;
      cal_start_q  <= 1'b0;
      write_file_q <= 1'b0;
      busy_q       <= 1'b0;
      finish_q     <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      count_q      <= count_d;
      off_q        <= off_d;
      line_q       <= line_d;
      file_idx_q   <= file_idx_d;
      read_file_q  <= read_file_d;
      write_reg1_q <= write_reg1_d;
      write_reg2_q <= write_reg2_d;
      cal_start_q  <= cal_start_d;
      write_file_q <= write_file_d;
      busy_q       <= busy_d;
      finish_q     <= finish_d;
      error_q      <= error_d;
    end
  end

  assign bus.read_file  = read_file_q;
  assign bus.write_reg1 = write_reg1_q;
  assign bus.write_reg2 = write_reg2_q;
  assign bus.cal_start  = cal_start_q;
  assign bus.write_file = write_file_q;
  assign bus.file_index = file_idx_q;
  assign bus.line_index = line_q;
  assign bus.busy       = busy_q;
  assign bus.finish     = finish_q;
  assign bus.error      = error_q;

endmodule
